// File: rtl/mem_stage_ctrl_pkg.sv
// Shared definitions for the MEM-stage control: request FSM encodings, default bus widths
// and the reset level.
package mem_stage_ctrl_pkg;

    localparam int unsigned AddrWDefault = 32;
    localparam int unsigned DataWDefault = 32;

    localparam logic RstEnable = 1'b0;

    localparam logic [2:0] StIdle    = 3'd0;
    localparam logic [2:0] StReq     = 3'd1;
    localparam logic [2:0] StWait    = 3'd2;
    localparam logic [2:0] StDone    = 3'd3;
    localparam logic [2:0] StDiscard = 3'd4;

endpackage

// File: rtl/mem_req_fsm.sv
// Data-RAM request sequencer: state register, registered request fields and the
// buffer that holds a load result while MEM->WB is stalled.
module mem_req_fsm
    import mem_stage_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W = AddrWDefault,
    parameter int unsigned DATA_W = DataWDefault
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              flush,
    input  logic              next_allowin,
    input  logic              addr_ok,
    input  logic              data_ok,
    input  logic              line_wr,
    input  logic [ADDR_W-1:0] line_addr,
    input  logic [DATA_W-1:0] line_wdata,
    input  logic [3:0]        line_wstrb,
    input  logic [DATA_W-1:0] rdata,
    output logic [2:0]        state,
    output logic              req_wr,
    output logic [ADDR_W-1:0] req_addr,
    output logic [DATA_W-1:0] req_wdata,
    output logic [3:0]        req_wstrb,
    output logic [DATA_W-1:0] rdata_buf
);

    logic [2:0]        state_q, state_d;
    logic              flushed_q, flushed_d;
    logic              capture;
    logic              buf_load;
    logic              wr_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [3:0]        wstrb_q;
    logic [DATA_W-1:0] rdata_buf_q;

    always_comb begin
        state_d   = state_q;
        flushed_d = flushed_q;
        capture   = 1'b0;
        buf_load  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d   = StReq;
                    flushed_d = 1'b0;
                    capture   = 1'b1;
                end
            end
            StReq: begin
                // req cannot be retracted, so a flush only marks the transaction as stale
                if (flush) begin
                    flushed_d = 1'b1;
                end
                if (addr_ok) begin
                    state_d = (flushed_q || flush) ? StDiscard : StWait;
                end
            end
            StWait: begin
                if (data_ok) begin
                    if (flush || next_allowin) begin
                        state_d = StIdle;
                    end else begin
                        state_d  = StDone;
                        buf_load = 1'b1;
                    end
                end else if (flush) begin
                    state_d = StDiscard;
                end
            end
            StDone: begin
                if (next_allowin || flush) begin
                    state_d = StIdle;
                end
            end
            StDiscard: begin
                if (data_ok) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (rst_n == RstEnable) begin
            state_q     <= StIdle;
            flushed_q   <= 1'b0;
            wr_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            rdata_buf_q <= '0;
        end else begin
            state_q   <= state_d;
            flushed_q <= flushed_d;
            if (capture) begin
                wr_q    <= line_wr;
                addr_q  <= line_addr;
                wdata_q <= line_wdata;
                wstrb_q <= line_wstrb;
            end
            if (buf_load) begin
                rdata_buf_q <= rdata;
            end
        end
    end

    assign state     = state_q;
    assign req_wr    = wr_q;
    assign req_addr  = addr_q;
    assign req_wdata = wdata_q;
    assign req_wstrb = wstrb_q;
    assign rdata_buf = rdata_buf_q;

endmodule

// File: rtl/mem_stage_ctrl.sv
// Consumer-side control of the dual-issue EX->MEM register: issues line1's data-RAM access
// and generates the stage handshake toward both neighbouring pipeline registers.
module mem_stage_ctrl
    import mem_stage_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W = AddrWDefault,
    parameter int unsigned DATA_W = DataWDefault
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              line1_now_valid_i,
    input  logic              line2_now_valid_i,
    input  logic              next_allowin_i,
    input  logic              excep_flush_i,
    input  logic              line1_mem_req_i,
    input  logic              line1_mem_wr_i,
    input  logic [ADDR_W-1:0] line1_addr_i,
    input  logic [DATA_W-1:0] line1_wdata_i,
    input  logic [3:0]        line1_wstrb_i,
    output logic              now_allowin_o,
    output logic              line1_now_to_next_valid_o,
    output logic              line2_now_to_next_valid_o,
    output logic [DATA_W-1:0] line1_rdata_o,
    output logic              data_sram_req_o,
    output logic              data_sram_wr_o,
    output logic [ADDR_W-1:0] data_sram_addr_o,
    output logic [DATA_W-1:0] data_sram_wdata_o,
    output logic [3:0]        data_sram_wstrb_o,
    input  logic              data_sram_addr_ok_i,
    input  logic              data_sram_data_ok_i,
    input  logic [DATA_W-1:0] data_sram_rdata_i
);

    logic [2:0]        state;
    logic [DATA_W-1:0] rdata_buf;
    logic              start;
    logic              ready_go;
    logic              any_valid;

    assign start = line1_now_valid_i & line1_mem_req_i & ~excep_flush_i;

    mem_req_fsm #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_fsm (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .flush        (excep_flush_i),
        .next_allowin (next_allowin_i),
        .addr_ok      (data_sram_addr_ok_i),
        .data_ok      (data_sram_data_ok_i),
        .line_wr      (line1_mem_wr_i),
        .line_addr    (line1_addr_i),
        .line_wdata   (line1_wdata_i),
        .line_wstrb   (line1_wstrb_i),
        .rdata        (data_sram_rdata_i),
        .state        (state),
        .req_wr       (data_sram_wr_o),
        .req_addr     (data_sram_addr_o),
        .req_wdata    (data_sram_wdata_o),
        .req_wstrb    (data_sram_wstrb_o),
        .rdata_buf    (rdata_buf)
    );

    // Both lines share line1's ready_go so the pair always advances together.
    always_comb begin
        ready_go = 1'b0;
        if (state == StDiscard) begin
            ready_go = 1'b0;
        end else if (!line1_mem_req_i) begin
            ready_go = 1'b1;
        end else begin
            unique case (state)
                StWait:  ready_go = data_sram_data_ok_i & ~excep_flush_i;
                StDone:  ready_go = 1'b1;
                default: ready_go = 1'b0;
            endcase
        end
    end

    assign any_valid = line1_now_valid_i | line2_now_valid_i;

    // A stale response is still owed while discarding, so nothing new may enter.
    assign now_allowin_o = (state != StDiscard) & (~any_valid | (ready_go & next_allowin_i));

    assign line1_now_to_next_valid_o = line1_now_valid_i & ready_go & ~excep_flush_i;
    assign line2_now_to_next_valid_o = line2_now_valid_i & ready_go & ~excep_flush_i;

    assign line1_rdata_o   = (state == StDone) ? rdata_buf : data_sram_rdata_i;
    assign data_sram_req_o = (state == StReq);

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl: loads, stalls, flushes, non-memory pairs, stores and reset.
module tb_mem_stage_ctrl;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          line1_now_valid_i, line2_now_valid_i, next_allowin_i, excep_flush_i;
    logic          line1_mem_req_i, line1_mem_wr_i;
    logic [AW-1:0] line1_addr_i;
    logic [DW-1:0] line1_wdata_i;
    logic [3:0]    line1_wstrb_i;
    logic          now_allowin_o, line1_now_to_next_valid_o, line2_now_to_next_valid_o;
    logic [DW-1:0] line1_rdata_o;
    logic          data_sram_req_o, data_sram_wr_o;
    logic [AW-1:0] data_sram_addr_o;
    logic [DW-1:0] data_sram_wdata_o;
    logic [3:0]    data_sram_wstrb_o;
    logic          data_sram_addr_ok_i, data_sram_data_ok_i;
    logic [DW-1:0] data_sram_rdata_i;

    int n_checks = 0;
    int n_pass = 0;

    mem_stage_ctrl #(
        .ADDR_W (AW),
        .DATA_W (DW)
    ) dut (
        .clk                       (clk),
        .rst_n                     (rst_n),
        .line1_now_valid_i         (line1_now_valid_i),
        .line2_now_valid_i         (line2_now_valid_i),
        .next_allowin_i            (next_allowin_i),
        .excep_flush_i             (excep_flush_i),
        .line1_mem_req_i           (line1_mem_req_i),
        .line1_mem_wr_i            (line1_mem_wr_i),
        .line1_addr_i              (line1_addr_i),
        .line1_wdata_i             (line1_wdata_i),
        .line1_wstrb_i             (line1_wstrb_i),
        .now_allowin_o             (now_allowin_o),
        .line1_now_to_next_valid_o (line1_now_to_next_valid_o),
        .line2_now_to_next_valid_o (line2_now_to_next_valid_o),
        .line1_rdata_o             (line1_rdata_o),
        .data_sram_req_o           (data_sram_req_o),
        .data_sram_wr_o            (data_sram_wr_o),
        .data_sram_addr_o          (data_sram_addr_o),
        .data_sram_wdata_o         (data_sram_wdata_o),
        .data_sram_wstrb_o         (data_sram_wstrb_o),
        .data_sram_addr_ok_i       (data_sram_addr_ok_i),
        .data_sram_data_ok_i       (data_sram_data_ok_i),
        .data_sram_rdata_i         (data_sram_rdata_i)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        line1_now_valid_i   = 1'b0;
        line2_now_valid_i   = 1'b0;
        next_allowin_i      = 1'b0;
        excep_flush_i       = 1'b0;
        line1_mem_req_i     = 1'b0;
        line1_mem_wr_i      = 1'b0;
        line1_addr_i        = '0;
        line1_wdata_i       = '0;
        line1_wstrb_i       = '0;
        data_sram_addr_ok_i = 1'b0;
        data_sram_data_ok_i = 1'b0;
        data_sram_rdata_i   = '0;
    endtask

    task automatic present_access(input logic wr, input logic [AW-1:0] addr,
                                  input logic [DW-1:0] wdata, input logic [3:0] wstrb);
        line1_now_valid_i = 1'b1;
        line2_now_valid_i = 1'b1;
        line1_mem_req_i   = 1'b1;
        line1_mem_wr_i    = wr;
        line1_addr_i      = addr;
        line1_wdata_i     = wdata;
        line1_wstrb_i     = wstrb;
    endtask

    task automatic drop_pair();
        line1_now_valid_i = 1'b0;
        line2_now_valid_i = 1'b0;
        line1_mem_req_i   = 1'b0;
        line1_mem_wr_i    = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 1'b0;
        repeat (2) cyc();
        n_checks++; if (now_allowin_o !== 1'b1)
            $display("FAIL reset_allowin: got %b want 1", now_allowin_o); else n_pass++;
        n_checks++; if (data_sram_req_o !== 1'b0)
            $display("FAIL reset_req: got %b want 0", data_sram_req_o); else n_pass++;
        n_checks++; if ({line1_now_to_next_valid_o, line2_now_to_next_valid_o} !== 2'b00)
            $display("FAIL reset_valids: got %b%b want 00",
                     line1_now_to_next_valid_o, line2_now_to_next_valid_o); else n_pass++;
        rst_n = 1'b1;
        cyc();
        n_checks++; if (now_allowin_o !== 1'b1 || data_sram_req_o !== 1'b0)
            $display("FAIL post_reset_idle: allowin %b req %b want 1 0",
                     now_allowin_o, data_sram_req_o); else n_pass++;
    endtask

    task automatic test_load_pass();
        cyc(); present_access(1'b0, 32'h1000, '0, 4'h0); next_allowin_i = 1'b1; #1;
        n_checks++; if (data_sram_req_o !== 1'b0 || now_allowin_o !== 1'b0)
            $display("FAIL load_entry: req %b allowin %b want 0 0",
                     data_sram_req_o, now_allowin_o); else n_pass++;
        cyc(); #1;
        n_checks++; if (data_sram_req_o !== 1'b1 || data_sram_addr_o !== 32'h1000
                        || data_sram_wr_o !== 1'b0)
            $display("FAIL load_req: req %b addr %h wr %b want 1 00001000 0",
                     data_sram_req_o, data_sram_addr_o, data_sram_wr_o); else n_pass++;
        cyc(); data_sram_addr_ok_i = 1'b1; #1;
        n_checks++; if (data_sram_req_o !== 1'b1)
            $display("FAIL load_req_held: got %b want 1", data_sram_req_o); else n_pass++;
        cyc(); data_sram_addr_ok_i = 1'b0; data_sram_data_ok_i = 1'b1;
        data_sram_rdata_i = 32'hDEADBEEF; #1;
        n_checks++; if ({line1_now_to_next_valid_o, line2_now_to_next_valid_o} !== 2'b11)
            $display("FAIL load_valids: got %b%b want 11",
                     line1_now_to_next_valid_o, line2_now_to_next_valid_o); else n_pass++;
        n_checks++; if (line1_rdata_o !== 32'hDEADBEEF || now_allowin_o !== 1'b1)
            $display("FAIL load_data: rdata %h allowin %b want deadbeef 1",
                     line1_rdata_o, now_allowin_o); else n_pass++;
        cyc(); data_sram_data_ok_i = 1'b0; data_sram_rdata_i = '0; drop_pair(); #1;
        n_checks++; if (data_sram_req_o !== 1'b0 || now_allowin_o !== 1'b1
                        || line1_now_to_next_valid_o !== 1'b0)
            $display("FAIL load_idle: req %b allowin %b v1 %b want 0 1 0",
                     data_sram_req_o, now_allowin_o, line1_now_to_next_valid_o); else n_pass++;
    endtask

    task automatic test_load_stall();
        cyc(); present_access(1'b0, 32'h1000, '0, 4'h0); next_allowin_i = 1'b0;
        cyc();
        cyc(); data_sram_addr_ok_i = 1'b1;
        cyc(); data_sram_addr_ok_i = 1'b0; data_sram_data_ok_i = 1'b1;
        data_sram_rdata_i = 32'hDEADBEEF; #1;
        n_checks++; if (line1_now_to_next_valid_o !== 1'b1 || now_allowin_o !== 1'b0)
            $display("FAIL stall_dataok: v1 %b allowin %b want 1 0",
                     line1_now_to_next_valid_o, now_allowin_o); else n_pass++;
        for (int i = 0; i < 3; i++) begin
            cyc(); data_sram_data_ok_i = 1'b0; data_sram_rdata_i = 32'h0BAD0BAD; #1;
            n_checks++; if (line1_rdata_o !== 32'hDEADBEEF || now_allowin_o !== 1'b0
                            || line1_now_to_next_valid_o !== 1'b1 || data_sram_req_o !== 1'b0)
                $display("FAIL stall_hold%0d: rdata %h allowin %b v1 %b req %b want deadbeef 0 1 0",
                         i, line1_rdata_o, now_allowin_o, line1_now_to_next_valid_o,
                         data_sram_req_o); else n_pass++;
        end
        cyc(); next_allowin_i = 1'b1; #1;
        n_checks++; if (now_allowin_o !== 1'b1 || line2_now_to_next_valid_o !== 1'b1
                        || line1_rdata_o !== 32'hDEADBEEF)
            $display("FAIL stall_release: allowin %b v2 %b rdata %h want 1 1 deadbeef",
                     now_allowin_o, line2_now_to_next_valid_o, line1_rdata_o); else n_pass++;
        cyc(); drop_pair(); data_sram_rdata_i = '0; #1;
        n_checks++; if (now_allowin_o !== 1'b1 || data_sram_req_o !== 1'b0)
            $display("FAIL stall_idle: allowin %b req %b want 1 0",
                     now_allowin_o, data_sram_req_o); else n_pass++;
    endtask

    task automatic test_flush_in_req();
        cyc(); present_access(1'b0, 32'h4000, '0, 4'h0); next_allowin_i = 1'b1;
        cyc(); excep_flush_i = 1'b1; #1;
        n_checks++; if (data_sram_req_o !== 1'b1 || line1_now_to_next_valid_o !== 1'b0)
            $display("FAIL flreq_flush: req %b v1 %b want 1 0",
                     data_sram_req_o, line1_now_to_next_valid_o); else n_pass++;
        cyc(); excep_flush_i = 1'b0; drop_pair(); #1;
        n_checks++; if (data_sram_req_o !== 1'b1 || data_sram_addr_o !== 32'h4000)
            $display("FAIL flreq_held: req %b addr %h want 1 00004000",
                     data_sram_req_o, data_sram_addr_o); else n_pass++;
        cyc(); data_sram_addr_ok_i = 1'b1; #1;
        cyc(); data_sram_addr_ok_i = 1'b0; present_access(1'b0, 32'h3000, '0, 4'h0); #1;
        n_checks++; if (data_sram_req_o !== 1'b0 || now_allowin_o !== 1'b0
                        || line1_now_to_next_valid_o !== 1'b0)
            $display("FAIL flreq_discard: req %b allowin %b v1 %b want 0 0 0",
                     data_sram_req_o, now_allowin_o, line1_now_to_next_valid_o); else n_pass++;
        cyc(); #1;
        n_checks++; if (data_sram_req_o !== 1'b0)
            $display("FAIL flreq_no_req: got %b want 0", data_sram_req_o); else n_pass++;
        cyc(); data_sram_data_ok_i = 1'b1; data_sram_rdata_i = 32'h11111111; #1;
        n_checks++; if (line1_now_to_next_valid_o !== 1'b0 || now_allowin_o !== 1'b0)
            $display("FAIL flreq_stale_drop: v1 %b allowin %b want 0 0",
                     line1_now_to_next_valid_o, now_allowin_o); else n_pass++;
        cyc(); data_sram_data_ok_i = 1'b0; data_sram_rdata_i = '0; #1;
        n_checks++; if (data_sram_req_o !== 1'b0)
            $display("FAIL flreq_idle_req: got %b want 0", data_sram_req_o); else n_pass++;
        cyc(); data_sram_addr_ok_i = 1'b1; #1;
        n_checks++; if (data_sram_req_o !== 1'b1 || data_sram_addr_o !== 32'h3000)
            $display("FAIL flreq_new_req: req %b addr %h want 1 00003000",
                     data_sram_req_o, data_sram_addr_o); else n_pass++;
        cyc(); data_sram_addr_ok_i = 1'b0; data_sram_data_ok_i = 1'b1;
        data_sram_rdata_i = 32'h22222222; #1;
        n_checks++; if (line1_now_to_next_valid_o !== 1'b1 || line1_rdata_o !== 32'h22222222)
            $display("FAIL flreq_new_data: v1 %b rdata %h want 1 22222222",
                     line1_now_to_next_valid_o, line1_rdata_o); else n_pass++;
        cyc(); data_sram_data_ok_i = 1'b0; data_sram_rdata_i = '0; drop_pair();
    endtask

    task automatic test_flush_with_data();
        cyc(); present_access(1'b0, 32'h5000, '0, 4'h0); next_allowin_i = 1'b1;
        cyc(); data_sram_addr_ok_i = 1'b1;
        cyc(); data_sram_addr_ok_i = 1'b0; data_sram_data_ok_i = 1'b1; excep_flush_i = 1'b1;
        data_sram_rdata_i = 32'h33333333; #1;
        n_checks++; if ({line1_now_to_next_valid_o, line2_now_to_next_valid_o} !== 2'b00)
            $display("FAIL fldata_valids: got %b%b want 00",
                     line1_now_to_next_valid_o, line2_now_to_next_valid_o); else n_pass++;
        cyc(); data_sram_data_ok_i = 1'b0; excep_flush_i = 1'b0; drop_pair(); #1;
        n_checks++; if (now_allowin_o !== 1'b1 || data_sram_req_o !== 1'b0)
            $display("FAIL fldata_idle: allowin %b req %b want 1 0",
                     now_allowin_o, data_sram_req_o); else n_pass++;
        cyc(); present_access(1'b0, 32'h5004, '0, 4'h0);
        cyc(); data_sram_addr_ok_i = 1'b1; #1;
        n_checks++; if (data_sram_req_o !== 1'b1 || data_sram_addr_o !== 32'h5004)
            $display("FAIL fldata_next_req: req %b addr %h want 1 00005004",
                     data_sram_req_o, data_sram_addr_o); else n_pass++;
        cyc(); data_sram_addr_ok_i = 1'b0; data_sram_data_ok_i = 1'b1;
        data_sram_rdata_i = 32'h44444444; #1;
        n_checks++; if (line1_now_to_next_valid_o !== 1'b1 || line1_rdata_o !== 32'h44444444)
            $display("FAIL fldata_next_data: v1 %b rdata %h want 1 44444444",
                     line1_now_to_next_valid_o, line1_rdata_o); else n_pass++;
        cyc(); data_sram_data_ok_i = 1'b0; data_sram_rdata_i = '0; drop_pair();
    endtask

    task automatic test_non_mem();
        cyc(); line1_now_valid_i = 1'b1; line2_now_valid_i = 1'b1; line1_mem_req_i = 1'b0;
        next_allowin_i = 1'b0; #1;
        n_checks++; if (now_allowin_o !== 1'b0 || line1_now_to_next_valid_o !== 1'b1)
            $display("FAIL nonmem_blocked: allowin %b v1 %b want 0 1",
                     now_allowin_o, line1_now_to_next_valid_o); else n_pass++;
        cyc(); next_allowin_i = 1'b1; #1;
        n_checks++; if ({line1_now_to_next_valid_o, line2_now_to_next_valid_o} !== 2'b11
                        || now_allowin_o !== 1'b1 || data_sram_req_o !== 1'b0)
            $display("FAIL nonmem_pass: v %b%b allowin %b req %b want 11 1 0",
                     line1_now_to_next_valid_o, line2_now_to_next_valid_o,
                     now_allowin_o, data_sram_req_o); else n_pass++;
        cyc(); drop_pair(); #1;
        n_checks++; if (data_sram_req_o !== 1'b0)
            $display("FAIL nonmem_no_req: got %b want 0", data_sram_req_o); else n_pass++;
    endtask

    task automatic test_store_and_reset();
        cyc(); present_access(1'b1, 32'h2004, 32'h0000A5A5, 4'h3); next_allowin_i = 1'b1;
        cyc(); #1;
        n_checks++; if (data_sram_req_o !== 1'b1 || data_sram_wr_o !== 1'b1
                        || data_sram_wstrb_o !== 4'h3 || data_sram_addr_o !== 32'h2004
                        || data_sram_wdata_o !== 32'h0000A5A5)
            $display("FAIL store_req: req %b wr %b strb %h addr %h wdata %h want 1 1 3 2004 a5a5",
                     data_sram_req_o, data_sram_wr_o, data_sram_wstrb_o,
                     data_sram_addr_o, data_sram_wdata_o); else n_pass++;
        // Disturb the source fields: the request must come from the captured copies.
        cyc(); line1_addr_i = 32'hFFFFFFF0; line1_wdata_i = '0; line1_wstrb_i = 4'hC;
        data_sram_addr_ok_i = 1'b1; #1;
        n_checks++; if (data_sram_req_o !== 1'b1 || data_sram_addr_o !== 32'h2004
                        || data_sram_wdata_o !== 32'h0000A5A5 || data_sram_wstrb_o !== 4'h3)
            $display("FAIL store_stable: req %b addr %h wdata %h strb %h want 1 2004 a5a5 3",
                     data_sram_req_o, data_sram_addr_o, data_sram_wdata_o,
                     data_sram_wstrb_o); else n_pass++;
        cyc(); data_sram_addr_ok_i = 1'b0;
        present_access(1'b1, 32'h2004, 32'h0000A5A5, 4'h3); #1;
        n_checks++; if (data_sram_req_o !== 1'b0 || line1_now_to_next_valid_o !== 1'b0)
            $display("FAIL store_wait: req %b v1 %b want 0 0",
                     data_sram_req_o, line1_now_to_next_valid_o); else n_pass++;
        cyc(); data_sram_data_ok_i = 1'b1; #1;
        n_checks++; if (line1_now_to_next_valid_o !== 1'b1 || now_allowin_o !== 1'b1)
            $display("FAIL store_retire: v1 %b allowin %b want 1 1",
                     line1_now_to_next_valid_o, now_allowin_o); else n_pass++;
        cyc(); data_sram_data_ok_i = 1'b0; drop_pair();
        cyc(); present_access(1'b1, 32'h2008, 32'h00005A5A, 4'hF);
        cyc(); data_sram_addr_ok_i = 1'b1;
        cyc(); data_sram_addr_ok_i = 1'b0; #1;
        rst_n = 1'b0; #1;
        n_checks++; if (data_sram_req_o !== 1'b0 || line1_now_to_next_valid_o !== 1'b0)
            $display("FAIL reset_in_wait: req %b v1 %b want 0 0",
                     data_sram_req_o, line1_now_to_next_valid_o); else n_pass++;
        drop_pair(); #1;
        n_checks++; if (now_allowin_o !== 1'b1)
            $display("FAIL reset_in_wait_allowin: got %b want 1", now_allowin_o); else n_pass++;
        cyc(); rst_n = 1'b1;
        cyc(); #1;
        n_checks++; if (data_sram_req_o !== 1'b0 || now_allowin_o !== 1'b1)
            $display("FAIL reset_release_idle: req %b allowin %b want 0 1",
                     data_sram_req_o, now_allowin_o); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_load_pass();
        test_load_stall();
        test_flush_in_req();
        test_flush_with_data();
        test_non_mem();
        test_store_and_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
